alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Command-side front end for the 8-bit ALU.
- Accepts register-based ALU commands on a valid/ready stream, holds a small register file, and drives the ALU's op/A/B inputs from registered outputs.
- Captures the ALU's combinational result C, writes it back to the register file and returns it on a valid/ready response stream.
- Sits between a host/controller and the combinational ALU; one command in flight at a time.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- NUM_REGS, 4, register-file depth; power of 2, >= 2. RA_W = clog2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_load  in  1  1 = load immediate, 0 = ALU execute
- cmd_op  in  3  ALU opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NAND, 101 NOR, 110 XOR, 111 XNOR
- cmd_dst  in  RA_W  destination register
- cmd_sa  in  RA_W  source register for ALU A
- cmd_sb  in  RA_W  source register for ALU B
- cmd_imm  in  DATA_W  immediate for load
- alu_op  out  3  to ALU op (registered)
- alu_a  out  DATA_W  to ALU A (registered)
- alu_b  out  DATA_W  to ALU B (registered)
- alu_c  in  DATA_W  from ALU C (combinational)
- res_valid  out  1  response present
- res_ready  in  1  consumer accepts response
- res_data  out  DATA_W  result (ALU C or immediate)
- res_zero  out  1  res_data == 0
- err  out  1  sticky self-check mismatch (see Optional Feature; tied 0 when disabled)

Behaviour:
- Reset (rst_n low, async): state IDLE; all RF entries 0; alu_op/alu_a/alu_b 0; res_data 0; res_zero 0; res_valid 0; err 0.
- cmd_ready = (state == IDLE), combinational. No flop changes while rst_n is low.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Handshake (cmd_valid & cmd_ready) at edge N latches the command.
  - If cmd_load = 1: rf[cmd_dst] <= cmd_imm; res_data <= cmd_imm; res_zero <= (cmd_imm == 0); res_valid <= 1; next state RESP. Response is visible after edge N.
  - If cmd_load = 0: alu_op <= cmd_op; alu_a <= rf[cmd_sa]; alu_b <= rf[cmd_sb]; latch cmd_dst; next state EXEC. The RF is read before any write at this edge.
- EXEC: lasts exactly one cycle; alu_c is sampled at edge N+1.
  - rf[dst] <= alu_c; res_data <= alu_c; res_zero <= (alu_c == 0); res_valid <= 1; next state RESP.
  - Latency, accept to res_valid: 2 edges for execute, 1 edge for load.
- RESP:
  - res_valid, res_data and res_zero are held stable until res_valid & res_ready.
  - On that edge: res_valid <= 0; next state IDLE; cmd_ready rises the following cycle (no back-to-back accept in the same edge as a response).
- ALU outputs hold their last values outside EXEC; they do not return to 0.
- Arithmetic: wrap-around modulo 2^DATA_W; there is no carry or borrow output. Examples: 0xFF + 0x01 = 0x00 with res_zero = 1; 0x00 - 0x01 = 0xFF.
- sa == sb == dst is legal: the old value feeds the ALU and the new value is written at the EXEC edge.
- cmd_* inputs are ignored outside IDLE.
- Reset mid-operation aborts immediately: any pending write-back is lost, res_valid drops, and the RF is cleared.

Optional Feature:
- Macro: ALU_CMD_SELFCHECK_EN.
- Defined:
  - An internal reference model computes the expected result from alu_op/alu_a/alu_b per the opcode table in Ports (OR = A|B), and compares it with alu_c at the EXEC edge.
  - On mismatch, err <= 1 and stays set until reset.
  - Write-back still uses alu_c.
- Undefined: no model logic is built; err is tied to 0.

Test Plan:
- Reset then load: after reset, LOAD r1 = 0x05, hold res_ready = 1 -> res_valid one cycle after accept, res_data = 0x05, res_zero = 0, cmd_ready back high 1 cycle later.
- ADD: r1 = 0x05, r2 = 0x03, EXEC ADD dst r3 sa r1 sb r2 -> alu_op = 000, alu_a = 0x05, alu_b = 0x03 in EXEC; res_data = 0x08 two edges after accept; a later read shows r3 = 0x08.
- Wrap and zero: r0 = 0xFF, r1 = 0x01, ADD dst r2 -> res_data = 0x00, res_zero = 1. Then SUB r2 - r1 dst r3 -> 0xFF.
- Backpressure: res_ready = 0 for 5 cycles after res_valid -> res_data stable, cmd_ready = 0, a cmd_valid pulse is ignored (not accepted); release -> IDLE.
- Aliasing: r0 = 0x0F, XOR dst r0 sa r0 sb r0 -> res_data = 0x00, r0 = 0x00.
- Self-check (macro defined): bench ALU model forced to return A&B for op 011, OR 0xF0|0x0F -> err = 1 and stays set; with the macro undefined, err stays 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command-side front end for the combinational 8-bit ALU.
// Accepts load/execute commands on a valid/ready stream, keeps a small
// register file, drives the ALU from registered operands, captures the ALU
// result and returns it on a valid/ready response stream.
//
// Optional build macro: ALU_CMD_SELFCHECK_EN
//   defined   -> internal reference model checks alu_c at the EXEC edge and
//                sets the sticky err flag on a mismatch
//   undefined -> no model logic, err tied to 0
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a command (cmd_ready high)
// EXEC  | ALU inputs driven, alu_c sampled and written back this cycle
// RESP  | response held on res_* until res_ready
module alu_cmd_sequencer #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    localparam int RA_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_op,
    input  logic [RA_W-1:0]   cmd_dst,
    input  logic [RA_W-1:0]   cmd_sa,
    input  logic [RA_W-1:0]   cmd_sb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] rf [NUM_REGS];
    logic [RA_W-1:0]   dst_q;
    logic              accept;
    logic              exec_wb;
    logic              res_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; loads skip EXEC since no ALU pass is needed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_load ? RESP : EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output strobes for the datapath.
    always_comb begin
        cmd_ready = (state == IDLE);
        accept    = cmd_valid & (state == IDLE);
        exec_wb   = (state == EXEC);
        res_done  = (state == RESP) & res_ready;
    end

    // Datapath: register file, ALU operand registers and response registers.
    // RF reads at accept see the pre-edge contents, so aliasing sa/sb/dst
    // feeds the old value to the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
            dst_q     <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_data  <= '0;
            res_zero  <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (cmd_load) begin
                    rf[cmd_dst] <= cmd_imm;
                    res_data    <= cmd_imm;
                    res_zero    <= (cmd_imm == '0);
                    res_valid   <= 1'b1;
                end else begin
                    alu_op <= cmd_op;
                    alu_a  <= rf[cmd_sa];
                    alu_b  <= rf[cmd_sb];
                    dst_q  <= cmd_dst;
                end
            end
            if (exec_wb) begin
                rf[dst_q] <= alu_c;
                res_data  <= alu_c;
                res_zero  <= (alu_c == '0);
                res_valid <= 1'b1;
            end
            if (res_done) res_valid <= 1'b0;
        end
    end

`ifdef ALU_CMD_SELFCHECK_EN
    logic [DATA_W-1:0] model_c;

    // Reference ALU evaluated on the registered operands.
    always_comb begin
        model_c = '0;
        case (alu_op)
            3'b000: model_c = alu_a + alu_b;
            3'b001: model_c = alu_a - alu_b;
            3'b010: model_c = alu_a & alu_b;
            3'b011: model_c = alu_a | alu_b;
            3'b100: model_c = ~(alu_a & alu_b);
            3'b101: model_c = ~(alu_a | alu_b);
            3'b110: model_c = alu_a ^ alu_b;
            3'b111: model_c = ~(alu_a ^ alu_b);
            default: model_c = '0;
        endcase
    end

    // Sticky mismatch flag, compared only when alu_c is actually consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err <= 1'b0;
        else if (exec_wb && (alu_c != model_c)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: vector table of commands with
// hand-computed results, plus hand-written backpressure, reset-abort and
// corrupted-ALU sequences.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_sa, cmd_sb;
    logic [7:0] cmd_imm;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_c;
    logic       res_valid, res_ready, res_zero, err;
    logic [7:0] res_data;

    logic       corrupt_or = 1'b0;
    logic       exp_err    = 1'b0;
    logic [7:0] mrf [4];
    int         n_pass  = 0;
    int         n_total = 0;

    typedef struct {
        logic       load;
        logic [2:0] op;
        logic [1:0] dst, sa, sb;
        logic [7:0] imm;
        logic [7:0] exp;
        logic       zero;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DATA_W(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
        .cmd_imm(cmd_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .err(err)
    );

    // Combinational ALU stand-in; corrupt_or makes OR behave as AND.
    always_comb begin
        alu_c = 8'h00;
        case (alu_op)
            3'b000: alu_c = alu_a + alu_b;
            3'b001: alu_c = alu_a - alu_b;
            3'b010: alu_c = alu_a & alu_b;
            3'b011: alu_c = corrupt_or ? (alu_a & alu_b) : (alu_a | alu_b);
            3'b100: alu_c = ~(alu_a & alu_b);
            3'b101: alu_c = ~(alu_a | alu_b);
            3'b110: alu_c = alu_a ^ alu_b;
            3'b111: alu_c = ~(alu_a ^ alu_b);
            default: alu_c = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic load, input logic [2:0] op,
                                input logic [1:0] dst, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [7:0] imm,
                                input logic [7:0] exp, input logic zero);
        vec_t v;
        v.load = load; v.op = op; v.dst = dst; v.sa = sa; v.sb = sb;
        v.imm = imm; v.exp = exp; v.zero = zero;
        return v;
    endfunction

    task automatic drive_cmd(input vec_t v);
        cmd_valid = 1'b1;
        cmd_load  = v.load;
        cmd_op    = v.op;
        cmd_dst   = v.dst;
        cmd_sa    = v.sa;
        cmd_sb    = v.sb;
        cmd_imm   = v.imm;
    endtask

    // One full command with res_ready held high; checks latency and values.
    task automatic run_cmd(input vec_t v);
        logic [7:0] ea, eb;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        ea = mrf[v.sa];
        eb = mrf[v.sb];
        drive_cmd(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (!v.load) begin
            @(negedge clk);
            chk("exec_res_valid_low", res_valid, 0);
            chk("exec_cmd_ready_low", cmd_ready, 0);
            chk("alu_op", alu_op, v.op);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
        end
        @(negedge clk);
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, v.exp);
        chk("res_zero", res_zero, v.zero);
        chk("err", err, exp_err);
        mrf[v.dst] = v.exp;
        @(negedge clk);
        chk("res_valid_drop", res_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        vec_t v;
        //               load op    dst sa sb imm    exp    zero
        vecs[0]  = mk(1, 3'd0, 1, 0, 0, 8'h05, 8'h05, 0); // LOAD r1
        vecs[1]  = mk(1, 3'd0, 2, 0, 0, 8'h03, 8'h03, 0); // LOAD r2
        vecs[2]  = mk(0, 3'd0, 3, 1, 2, 8'h00, 8'h08, 0); // ADD r3=r1+r2
        vecs[3]  = mk(0, 3'd3, 3, 3, 3, 8'h00, 8'h08, 0); // read r3
        vecs[4]  = mk(1, 3'd0, 0, 0, 0, 8'hFF, 8'hFF, 0); // LOAD r0
        vecs[5]  = mk(1, 3'd0, 1, 0, 0, 8'h01, 8'h01, 0); // LOAD r1
        vecs[6]  = mk(0, 3'd0, 2, 0, 1, 8'h00, 8'h00, 1); // ADD wrap
        vecs[7]  = mk(0, 3'd1, 3, 2, 1, 8'h00, 8'hFF, 0); // SUB 0-1
        vecs[8]  = mk(1, 3'd0, 2, 0, 0, 8'h3C, 8'h3C, 0); // LOAD r2
        vecs[9]  = mk(0, 3'd2, 3, 3, 2, 8'h00, 8'h3C, 0); // AND FF&3C
        vecs[10] = mk(0, 3'd4, 1, 2, 3, 8'h00, 8'hC3, 0); // NAND 3C,3C
        vecs[11] = mk(0, 3'd5, 1, 1, 2, 8'h00, 8'h00, 1); // NOR C3,3C
        vecs[12] = mk(0, 3'd7, 2, 2, 0, 8'h00, 8'h3C, 0); // XNOR 3C,FF
        vecs[13] = mk(1, 3'd0, 0, 0, 0, 8'h0F, 8'h0F, 0); // LOAD r0
        vecs[14] = mk(0, 3'd6, 0, 0, 0, 8'h00, 8'h00, 1); // XOR alias
        vecs[15] = mk(0, 3'd3, 1, 0, 0, 8'h00, 8'h00, 1); // read r0
        vecs[16] = mk(1, 3'd0, 0, 0, 0, 8'h00, 8'h00, 1); // LOAD zero

        rst_n = 1'b0; res_ready = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
        cmd_op = '0; cmd_dst = '0; cmd_sa = '0; cmd_sb = '0; cmd_imm = '0;
        for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_zero", res_zero, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_cmd(vecs[i]);

        // Backpressure: response held for 5 cycles, a command pulse ignored.
        res_ready = 1'b0;
        @(negedge clk);
        drive_cmd(mk(1, 3'd0, 1, 0, 0, 8'hAA, 8'hAA, 0));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_valid", res_valid, 1);
            chk("bp_res_data", res_data, 8'hAA);
            chk("bp_cmd_ready", cmd_ready, 0);
            cmd_valid = 1'b0;
            if (i == 2) drive_cmd(mk(1, 3'd0, 1, 0, 0, 8'h11, 8'h11, 0));
            if (i == 4) res_ready = 1'b1;
        end
        @(negedge clk);
        chk("bp_release_valid", res_valid, 0);
        chk("bp_release_ready", cmd_ready, 1);
        mrf[1] = 8'hAA;
        run_cmd(mk(0, 3'd3, 1, 1, 1, 8'h00, 8'hAA, 0));

        // Reset during EXEC drops the pending write-back and clears the RF.
        @(negedge clk);
        drive_cmd(mk(0, 3'd0, 3, 1, 1, 8'h00, 8'h54, 0));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_alu_a", alu_a, 8'hAA);
        rst_n = 1'b0;
        #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_alu_a_clr", alu_a, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        chk("abort_held_valid", res_valid, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
        run_cmd(mk(0, 3'd3, 3, 3, 3, 8'h00, 8'h00, 1));
        run_cmd(mk(0, 3'd3, 1, 1, 1, 8'h00, 8'h00, 1));

        // Faulty ALU: OR returns A&B; write-back still takes alu_c.
        run_cmd(mk(1, 3'd0, 0, 0, 0, 8'hF0, 8'hF0, 0));
        run_cmd(mk(1, 3'd0, 1, 0, 0, 8'h0F, 8'h0F, 0));
        corrupt_or = 1'b1;
`ifdef ALU_CMD_SELFCHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_cmd(mk(0, 3'd3, 2, 0, 1, 8'h00, 8'h00, 1));
        corrupt_or = 1'b0;
        v = mk(0, 3'd6, 3, 0, 1, 8'h00, 8'hFF, 0);
        run_cmd(v);
        chk("err_sticky", err, exp_err);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
